gate_bist_ctrl: RTL and testbench

Synchronous built-in self-test controller for the basic two-input gate library (`basic_gates` plus `xor_using_nand`). It is the driving and checking end of the gate interface. On request it sweeps the inputs `a`/`b` through all four vectors and samples the eight gate outputs. It compares each sample against a golden truth table, then reports pass/fail, an error count, and the first failing vector. It sits beside the gate instances and replaces the simulation-only stimulus/monitor flow with synthesizable hardware.

---
 rtl/gate_bist_pkg.sv | 36 +++
 rtl/gate_bist_if.sv | 31 +++
 rtl/gate_golden.sv | 12 +
 rtl/gate_bist_ctrl.sv | 173 +++++++++++++++++
 tb/tb_gate_bist_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_bist_pkg.sv
// Shared types and the golden truth table for the two-input gate library BIST.
// Bit positions in resp follow the gate order of the library.
package gate_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int RESP_AND      = 0;
  localparam int RESP_OR       = 1;
  localparam int RESP_NOT      = 2;
  localparam int RESP_NAND     = 3;
  localparam int RESP_NOR      = 4;
  localparam int RESP_XOR      = 5;
  localparam int RESP_XNOR     = 6;
  localparam int RESP_XOR_NAND = 7;

  function automatic logic [7:0] golden_resp(input logic a, input logic b);
    logic [7:0] g;
    g                = '0;
    g[RESP_AND]      = a & b;
    g[RESP_OR]       = a | b;
    g[RESP_NOT]      = ~a;
    g[RESP_NAND]     = ~(a & b);
    g[RESP_NOR]      = ~(a | b);
    g[RESP_XOR]      = a ^ b;
    g[RESP_XNOR]     = ~(a ^ b);
    g[RESP_XOR_NAND] = a ^ b;
    return g;
  endfunction

endpackage

// File: rtl/gate_bist_if.sv
// Stimulus, response and result signals between the BIST controller and its host.
// master = controller side, slave = host / gate-array side.
interface gate_bist_if #(
  parameter int ERR_W = 8
);

  logic             start;
  logic             a;
  logic             b;
  logic [7:0]       resp;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic             fail_valid;
  logic [1:0]       first_fail_vec;
  logic [7:0]       first_fail_mask;

  modport master (
    input  start, resp,
    output a, b, busy, done, pass, err_count, fail_valid,
           first_fail_vec, first_fail_mask
  );

  modport slave (
    output start, resp,
    input  a, b, busy, done, pass, err_count, fail_valid,
           first_fail_vec, first_fail_mask
  );

endinterface

// File: rtl/gate_golden.sv
// Combinational golden response for one {a,b} vector.
module gate_golden
  import gate_bist_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [7:0] golden
);

  assign golden = golden_resp(a, b);

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST controller: sweeps {a,b} over all four vectors, checks the gate
// responses against the golden table and reports pass / error statistics.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | a=b=0, results held, waiting for start
// APPLY  | register {a,b} from the vector index (one cycle)
// SETTLE | hold {a,b} for SETTLE_CYCLES while the gates settle
// CHECK  | compare resp with golden, update error statistics
// DONE   | one-cycle done pulse, pass valid, then back to IDLE
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input  logic         clk,
  input  logic         rst,
  gate_bist_if.master  bus
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [PW-1:0]    pidx_q, pidx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fv_q, fv_d;
  logic [1:0]       ffv_q, ffv_d;
  logic [7:0]       ffm_q, ffm_d;

  logic [7:0]       golden;
  logic [7:0]       mask;
  logic             mismatch;

  gate_golden u_golden (
    .a      (a_q),
    .b      (b_q),
    .golden (golden)
  );

  assign mask     = bus.resp ^ golden;
  assign mismatch = |mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      pidx_q  <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ffv_q   <= '0;
      ffm_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      pidx_q  <= pidx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ffv_q   <= ffv_d;
      ffm_q   <= ffm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    pidx_d  = pidx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ffv_d   = ffv_q;
    ffm_d   = ffm_q;

    unique case (state_q)
      ST_IDLE: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (bus.start) begin
          state_d = ST_APPLY;
          vec_d   = '0;
          pidx_d  = '0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = '0;
          fv_d    = 1'b0;
          ffv_d   = '0;
          ffm_d   = '0;
        end
      end

      ST_APPLY: begin
        a_d     = vec_q[1];
        b_d     = vec_q[0];
        cnt_d   = CW'(SETTLE_CYCLES - 1);
        state_d = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_CHECK;
        else             cnt_d   = cnt_q - CW'(1);
      end

      ST_CHECK: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
          // Only the first failing vector of a run is recorded.
          if (!fv_q) begin
            fv_d  = 1'b1;
            ffv_d = {a_q, b_q};
            ffm_d = mask;
          end
        end
        if (vec_q != 2'd3) begin
          vec_d   = vec_q + 2'd1;
          state_d = ST_APPLY;
        end else if (pidx_q != PW'(PASSES - 1)) begin
          vec_d   = '0;
          pidx_d  = pidx_q + PW'(1);
          state_d = ST_APPLY;
        end else begin
          state_d = ST_DONE;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = ~(fv_q | mismatch);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.a               = a_q;
  assign bus.b               = b_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_q;
  assign bus.fail_valid      = fv_q;
  assign bus.first_fail_vec  = ffv_q;
  assign bus.first_fail_mask = ffm_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: behavioural gate array with injectable faults,
// scoreboard of expected run results popped on each done pulse.
module tb_gate_bist_ctrl;

  typedef struct packed {
    logic       pass;
    logic [7:0] err;
    logic       fv;
    logic [1:0] ffv;
    logic [7:0] ffm;
  } exp_t;

  // Golden responses for {a,b} = 00, 01, 10, 11
  localparam logic [7:0] GOLD [4] = '{8'h5C, 8'hAE, 8'hAA, 8'h43};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   fault_mode = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   busy_cnt = 0;
  exp_t sb_q [$];

  logic       gg_a, gg_b;
  logic [7:0] gg_out;

  always #5 clk = ~clk;

  gate_bist_if #(.ERR_W(8)) bus ();
  gate_bist_if #(.ERR_W(2)) bus3 ();

  gate_bist_ctrl #(.SETTLE_CYCLES(2), .PASSES(1), .ERR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  gate_bist_ctrl #(.SETTLE_CYCLES(2), .PASSES(3), .ERR_W(2)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  gate_golden gg (.a(gg_a), .b(gg_b), .golden(gg_out));

  // mode 0 good, 1 and stuck-at-0, 2 xor_nand inverted, 3 all ones
  function automatic logic [7:0] gate_resp(input int mode, input logic a, input logic b);
    logic [7:0] r;
    logic       n1;
    if (mode == 3) return 8'hFF;
    n1   = ~(a & b);
    r[0] = a & b;
    r[1] = a | b;
    r[2] = ~a;
    r[3] = ~(a & b);
    r[4] = ~(a | b);
    r[5] = a ^ b;
    r[6] = ~(a ^ b);
    r[7] = ~(~(a & n1) & ~(b & n1));
    if (mode == 1) r[0] = 1'b0;
    if (mode == 2) r[7] = ~r[7];
    return r;
  endfunction

  function automatic exp_t model(input int mode, input int passes, input int err_max);
    exp_t       e;
    logic [7:0] r;
    e = '0;
    for (int p = 0; p < passes; p++) begin
      for (int v = 0; v < 4; v++) begin
        r = gate_resp(mode, v[1], v[0]);
        if (r != GOLD[v]) begin
          if (int'(e.err) < err_max) e.err = e.err + 8'd1;
          if (!e.fv) begin
            e.fv  = 1'b1;
            e.ffv = v[1:0];
            e.ffm = r ^ GOLD[v];
          end
        end
      end
    end
    e.pass = ~e.fv;
    return e;
  endfunction

  assign bus.resp  = gate_resp(fault_mode, bus.a, bus.b);
  assign bus3.resp = 8'hFF;

  always @(negedge clk) begin
    if (bus.done) done_cnt <= done_cnt + 1;
    if (bus.busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_compare(input string pfx, input logic pass, input logic [7:0] err,
                            input logic fv, input logic [1:0] ffv, input logic [7:0] ffm);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({pfx, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    chk({pfx, "_pass"}, 32'(pass), 32'(e.pass));
    chk({pfx, "_err"},  32'(err),  32'(e.err));
    chk({pfx, "_fv"},   32'(fv),   32'(e.fv));
    chk({pfx, "_ffv"},  32'(ffv),  32'(e.ffv));
    chk({pfx, "_ffm"},  32'(ffm),  32'(e.ffm));
  endtask

  task automatic run_bist(input string pfx, input int mode, input bit repulse);
    exp_t e;
    int   n, d0, b0;
    fault_mode = mode;
    e = model(mode, 1, 255);
    sb_q.push_back(e);
    d0 = done_cnt;
    b0 = busy_cnt;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({pfx, "_busy_on"}, 32'(bus.busy), 32'd1);
    n = 1;
    while (!bus.done && n < 100) begin
      bus.start = (repulse && n == 6);
      tick();
      n++;
    end
    bus.start = 1'b0;
    chk({pfx, "_done_cycle"}, 32'(n), 32'd17);
    if (!bus.done) return;
    chk({pfx, "_busy_in_done"}, 32'(bus.busy), 32'd0);
    sb_compare(pfx, bus.pass, bus.err_count, bus.fail_valid, bus.first_fail_vec,
               bus.first_fail_mask);
    bus.start = repulse;
    tick();
    bus.start = 1'b0;
    chk({pfx, "_done_pulse"}, 32'(bus.done), 32'd0);
    tick();
    tick();
    chk({pfx, "_no_restart"}, 32'(bus.busy), 32'd0);
    chk({pfx, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    chk({pfx, "_busy_len"}, 32'(busy_cnt - b0), 32'd16);
    chk({pfx, "_err_held"}, 32'(bus.err_count), 32'(e.err));
    chk({pfx, "_ab_idle"}, 32'({bus.a, bus.b}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, d0;
    exp_t e;
    bus.start  = 1'b0;
    bus3.start = 1'b0;
    gg_a = 1'b0;
    gg_b = 1'b0;

    for (int v = 0; v < 4; v++) begin
      {gg_a, gg_b} = v[1:0];
      #1;
      chk($sformatf("golden_v%0d", v), 32'(gg_out), 32'(GOLD[v]));
    end

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_a",    32'(bus.a), 32'd0);
    chk("rst_b",    32'(bus.b), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_pass", 32'(bus.pass), 32'd0);
    chk("rst_err",  32'(bus.err_count), 32'd0);
    chk("rst_fv",   32'(bus.fail_valid), 32'd0);
    chk("rst_ffv",  32'(bus.first_fail_vec), 32'd0);
    chk("rst_ffm",  32'(bus.first_fail_mask), 32'd0);
    chk("rst_err3", 32'(bus3.err_count), 32'd0);
    tick();

    run_bist("good", 0, 1'b0);
    run_bist("and_sa0", 1, 1'b0);
    run_bist("xn_inv", 2, 1'b0);
    run_bist("repulse", 1, 1'b1);

    // Abort during CHECK of vector 2 with a faulty gate array
    fault_mode = 2;
    d0 = done_cnt;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (11) tick();
    chk("mid_err",  32'(bus.err_count), 32'd2);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    chk("mid_ab",   32'({bus.a, bus.b}), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ab",   32'({bus.a, bus.b}), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_err",  32'(bus.err_count), 32'd0);
    chk("abort_fv",   32'(bus.fail_valid), 32'd0);
    chk("abort_ffm",  32'(bus.first_fail_mask), 32'd0);
    repeat (20) tick();
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_bist("after_rst", 0, 1'b0);

    // Three passes, 2-bit counter, every output stuck high
    e = model(3, 3, 3);
    sb_q.push_back(e);
    bus3.start = 1'b1;
    tick();
    bus3.start = 1'b0;
    n = 1;
    while (!bus3.done && n < 400) begin
      tick();
      n++;
    end
    chk("p3_done_cycle", 32'(n), 32'd49);
    if (bus3.done)
      sb_compare("p3", bus3.pass, 8'(bus3.err_count), bus3.fail_valid,
                 bus3.first_fail_vec, bus3.first_fail_mask);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
